// File: rtl/div_arbiter_pkg.sv
// ---------------------------------------------------------------------------
// div_arb_pkg
// Shared definitions for the divider arbiter/sequencer:
//   - state_e   : 2-bit sequencer state encoding
//   - ERR_*     : response error codes
//   - DEF_WIDTH : default operand/result width
// ---------------------------------------------------------------------------
package div_arb_pkg;

    localparam int DEF_WIDTH = 8;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_RUN     = 2'd1,
        ST_DONE    = 2'd2,
        ST_RELEASE = 2'd3
    } state_e;

    localparam logic [1:0] ERR_OK = 2'b00;  // divider result
    localparam logic [1:0] ERR_DZ = 2'b01;  // divide-by-zero, divider not used
    localparam logic [1:0] ERR_TO = 2'b10;  // watchdog expired

endpackage

// File: rtl/div_arbiter_if.sv
// ---------------------------------------------------------------------------
// div_arbiter_if
// Bundles the requester handshakes, the response bus and the divider
// control/result signals of div_arbiter.
//   slave  : the arbiter side (takes requests and divider results,
//            drives ready/response/divider controls)
//   master : the environment side (requesters, response sink, divider)
// ---------------------------------------------------------------------------
interface div_arbiter_if
    import div_arb_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH
);
    // requester handshakes
    logic             req0_valid;
    logic             req1_valid;
    logic             req0_ready;
    logic             req1_ready;
    logic [WIDTH-1:0] req0_a;
    logic [WIDTH-1:0] req0_b;
    logic [WIDTH-1:0] req1_a;
    logic [WIDTH-1:0] req1_b;

    // response pulse
    logic             rsp_valid;
    logic             rsp_id;
    logic [WIDTH-1:0] rsp_q;
    logic [WIDTH-1:0] rsp_r;
    logic [1:0]       rsp_err;

    // status and divider side
    logic             busy;
    logic             div_start;
    logic [WIDTH-1:0] div_a;
    logic [WIDTH-1:0] div_b;
    logic             div_done;
    logic [WIDTH-1:0] div_q;
    logic [WIDTH-1:0] div_r;

    modport slave (
        input  req0_valid, req1_valid, req0_a, req0_b, req1_a, req1_b,
        input  div_done, div_q, div_r,
        output req0_ready, req1_ready,
        output rsp_valid, rsp_id, rsp_q, rsp_r, rsp_err,
        output busy, div_start, div_a, div_b
    );

    modport master (
        output req0_valid, req1_valid, req0_a, req0_b, req1_a, req1_b,
        output div_done, div_q, div_r,
        input  req0_ready, req1_ready,
        input  rsp_valid, rsp_id, rsp_q, rsp_r, rsp_err,
        input  busy, div_start, div_a, div_b
    );

endinterface

// File: rtl/div_arbiter_rr_arbiter2.sv
// ---------------------------------------------------------------------------
// rr_arbiter2
// Two-way round-robin grant, purely combinational.
//   i_valid[1:0] : request lines
//   i_last       : index of the requester served most recently
//   o_grant[1:0] : one-hot grant (all zero when nobody requests)
// A lone requester always wins; on a tie the one not served last wins.
// ---------------------------------------------------------------------------
module rr_arbiter2 (
    input  logic [1:0] i_valid,
    input  logic       i_last,
    output logic [1:0] o_grant
);

    assign o_grant[0] = i_valid[0] & (~i_valid[1] |  i_last);
    assign o_grant[1] = i_valid[1] & (~i_valid[0] | ~i_last);

endmodule

// File: rtl/div_arbiter.sv
// ---------------------------------------------------------------------------
// div_arbiter
// Round-robin arbiter and sequencer in front of a shared restoring divider.
// Accepts one divide job at a time from two requesters, holds the divider's
// level start while it works, collects quotient/remainder on its done flag
// and emits a one-cycle tagged response. Divide-by-zero is answered locally;
// a divider that never finishes is abandoned after TIMEOUT RUN cycles.
//
// Ports:
//   clk      : single clock, rising edge
//   rst_n    : synchronous active-low reset
//   bus      : div_arbiter_if.slave
//              req{0,1}_valid/ready/a/b : request handshakes
//              rsp_valid/id/q/r/err     : response pulse (no backpressure)
//              busy                     : not in IDLE
//              div_start/a/b            : divider controls (registered)
//              div_done/q/r             : divider results
//
// Parameters:
//   WIDTH    : operand/result width
//   TIMEOUT  : RUN cycles allowed before the watchdog fires (>= 2)
//   REL_CYC  : cycles div_start stays low after a divider job (>= 1)
// ---------------------------------------------------------------------------
module div_arbiter
    import div_arb_pkg::*;
#(
    parameter int WIDTH   = DEF_WIDTH,
    parameter int TIMEOUT = 64,
    parameter int REL_CYC = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    div_arbiter_if.slave bus
);

    localparam logic [1:0] S_IDLE    = ST_IDLE;
    localparam logic [1:0] S_RUN     = ST_RUN;
    localparam logic [1:0] S_DONE    = ST_DONE;
    localparam logic [1:0] S_RELEASE = ST_RELEASE;

    // One counter serves both the RUN watchdog and the RELEASE hold-off,
    // since the two phases never overlap.
    localparam int CNT_MAX = (TIMEOUT > REL_CYC) ? TIMEOUT : REL_CYC;
    localparam int CW      = $clog2(CNT_MAX) + 1;

    localparam logic [CW-1:0] CNT_TO  = CW'(TIMEOUT - 1);
    localparam logic [CW-1:0] CNT_REL = CW'(REL_CYC - 1);

    logic [1:0]       r_state;
    logic             r_last;
    logic [CW-1:0]    r_cnt;
    logic             r_id;
    logic [WIDTH-1:0] r_a;
    logic [WIDTH-1:0] r_b;
    logic [WIDTH-1:0] r_q;
    logic [WIDTH-1:0] r_r;
    logic [1:0]       r_err;

    logic [1:0]       w_gnt;
    logic             w_idle;
    logic             w_hs;
    logic             w_hs_id;
    logic [WIDTH-1:0] w_a;
    logic [WIDTH-1:0] w_b;

    rr_arbiter2 u_rr (
        .i_valid ({bus.req1_valid, bus.req0_valid}),
        .i_last  (r_last),
        .o_grant (w_gnt)
    );

    // Ready is gated by rst_n so nothing can be accepted, or appear to be,
    // while reset is being held.
    assign w_idle  = (r_state == S_IDLE) && rst_n;
    assign w_hs    = w_idle && (|w_gnt);
    assign w_hs_id = w_gnt[1];
    assign w_a     = w_hs_id ? bus.req1_a : bus.req0_a;
    assign w_b     = w_hs_id ? bus.req1_b : bus.req0_b;

    assign bus.req0_ready = w_idle && w_gnt[0];
    assign bus.req1_ready = w_idle && w_gnt[1];

    // Everything else is a state decode or a register.
    assign bus.busy      = (r_state != S_IDLE);
    assign bus.div_start = (r_state == S_RUN);
    assign bus.div_a     = r_a;
    assign bus.div_b     = r_b;
    assign bus.rsp_valid = (r_state == S_DONE);
    assign bus.rsp_id    = r_id;
    assign bus.rsp_q     = r_q;
    assign bus.rsp_r     = r_r;
    assign bus.rsp_err   = r_err;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
            r_last  <= 1'b1;        // requester 0 wins the first tie
            r_cnt   <= '0;
            r_id    <= 1'b0;
            r_a     <= '0;
            r_b     <= '0;
            r_q     <= '0;
            r_r     <= '0;
            r_err   <= ERR_OK;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_hs) begin
                        r_id   <= w_hs_id;
                        r_last <= w_hs_id;
                        r_a    <= w_a;
                        r_b    <= w_b;
                        if (w_b == '0) begin
                            // answered without touching the divider
                            r_q     <= '1;
                            r_r     <= w_a;
                            r_err   <= ERR_DZ;
                            r_state <= S_DONE;
                        end else begin
                            r_cnt   <= '0;
                            r_state <= S_RUN;
                        end
                    end
                end

                S_RUN: begin
                    // div_done is checked first so it wins a tie with the
                    // last watchdog cycle.
                    if (bus.div_done) begin
                        r_q     <= bus.div_q;
                        r_r     <= bus.div_r;
                        r_err   <= ERR_OK;
                        r_state <= S_DONE;
                    end else if (r_cnt == CNT_TO) begin
                        r_q     <= '0;
                        r_r     <= '0;
                        r_err   <= ERR_TO;
                        r_state <= S_DONE;
                    end else begin
                        r_cnt <= r_cnt + CW'(1);
                    end
                end

                S_DONE: begin
                    // Any job that held div_start must let the divider fall
                    // back to its initial state before the next one.
                    if (r_err != ERR_DZ) begin
                        r_cnt   <= '0;
                        r_state <= S_RELEASE;
                    end else begin
                        r_state <= S_IDLE;
                    end
                end

                S_RELEASE: begin
                    if (r_cnt == CNT_REL) begin
                        r_state <= S_IDLE;
                    end else begin
                        r_cnt <= r_cnt + CW'(1);
                    end
                end

                default: r_state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_div_arbiter.sv
// ---------------------------------------------------------------------------
// tb_div_arbiter
// Self-checking bench for div_arbiter: a directed vector table, a few
// multi-cycle sequences (tie fairness, stray done, reset mid-RUN) and a
// randomized run checked against an arithmetic reference model.
// A behavioural divider answers div_start after a programmable delay.
// ---------------------------------------------------------------------------
module tb_div_arbiter;
    import div_arb_pkg::*;

    localparam int W       = 8;
    localparam int TIMEOUT = 64;
    localparam int REL_CYC = 2;

    logic clk;
    logic rst_n;

    div_arbiter_if #(.WIDTH(W)) bus ();

    div_arbiter #(.WIDTH(W), .TIMEOUT(TIMEOUT), .REL_CYC(REL_CYC)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks    = 0;
    int failures  = 0;
    int cyc       = 0;
    int ready_bad = 0;
    int start_cnt = 0;
    int rsp_cnt   = 0;
    bit m_last    = 1'b1;   // reference model's round-robin pointer

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (rst_n && bus.busy && (bus.req0_ready || bus.req1_ready)) ready_bad <= ready_bad + 1;
        if (rst_n && bus.req0_ready && bus.req1_ready) ready_bad <= ready_bad + 1;
        if (bus.div_start) start_cnt <= start_cnt + 1;
        if (bus.rsp_valid) rsp_cnt <= rsp_cnt + 1;
    end

    // Behavioural divider: done rises 'dly_cfg' cycles after start rises
    // and stays up while start is held; dly_cfg < 0 means it never finishes.
    int   dly_cfg = -1;
    int   run_cyc = 0;
    logic spur    = 1'b0;

    always @(posedge clk) run_cyc <= bus.div_start ? run_cyc + 1 : 0;

    assign bus.div_done = spur | (bus.div_start && (dly_cfg >= 0) && (run_cyc >= dly_cfg));
    assign bus.div_q    = (bus.div_b != '0) ? bus.div_a / bus.div_b : '1;
    assign bus.div_r    = (bus.div_b != '0) ? bus.div_a % bus.div_b : '1;

    task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0d exp=%0d", nm, got, exp);
        end
    endtask

    // Expected outcome of one job straight from the arbitration and
    // divider rules.
    function automatic void ref_model(input bit v0, v1, input logic [W-1:0] a0, b0, a1, b1,
                                      input int dly, output bit id, output logic [W-1:0] q, r,
                                      output logic [1:0] err, output int lat);
        logic [W-1:0] a, b;
        id = (v0 && v1) ? ~m_last : v1;
        a  = id ? a1 : a0;
        b  = id ? b1 : b0;
        if (b == 0) begin
            q = '1; r = a; err = ERR_DZ; lat = 1;
        end else if (dly >= 0 && dly <= TIMEOUT - 1) begin
            q = a / b; r = a % b; err = ERR_OK; lat = dly + 2;
        end else begin
            q = 0; r = 0; err = ERR_TO; lat = TIMEOUT + 1;
        end
    endfunction

    task automatic drop_valids();
        bus.req0_valid = 1'b0;
        bus.req1_valid = 1'b0;
    endtask

    // Called at a falling edge. Presents a request, then follows the job
    // through response and back to IDLE, checking every observable step.
    task automatic run_job(input string nm, input bit v0, v1, input logic [W-1:0] a0, b0, a1, b1,
                           input int dly, input bit hold, input bit eid, input logic [W-1:0] eq, er,
                           input logic [1:0] eerr, input int elat);
        int t, n, s0;
        logic [W-1:0] ea, eb;
        ea = eid ? a1 : a0;
        eb = eid ? b1 : b0;
        n = 0;
        while (bus.busy && n < 300) begin @(negedge clk); n++; end
        dly_cfg = dly;
        bus.req0_a = a0; bus.req0_b = b0; bus.req1_a = a1; bus.req1_b = b1;
        bus.req0_valid = v0; bus.req1_valid = v1;
        #1;
        n = 0;
        while (!(bus.req0_ready || bus.req1_ready) && n < 5) begin @(negedge clk); #1; n++; end
        chk({nm, " grant_seen"}, 64'(n < 5), 1);
        if (n >= 5) begin drop_valids(); return; end
        chk({nm, " grant_id"}, bus.req1_ready, eid);
        t  = cyc;
        s0 = start_cnt;
        @(negedge clk);
        if (!hold) drop_valids();
        if (eerr != ERR_DZ) begin
            chk({nm, " start_T+1"}, bus.div_start, 1);
            chk({nm, " div_a"}, bus.div_a, ea);
            chk({nm, " div_b"}, bus.div_b, eb);
        end
        n = 0;
        while (!bus.rsp_valid && n < 200) begin @(negedge clk); n++; end
        chk({nm, " rsp_seen"}, bus.rsp_valid, 1);
        chk({nm, " latency"}, 64'(cyc - t), 64'(elat));
        chk({nm, " rsp_id"}, bus.rsp_id, eid);
        chk({nm, " rsp_q"}, bus.rsp_q, eq);
        chk({nm, " rsp_r"}, bus.rsp_r, er);
        chk({nm, " rsp_err"}, bus.rsp_err, eerr);
        @(negedge clk);
        chk({nm, " rsp_pulse"}, bus.rsp_valid, 0);
        if (eerr == ERR_DZ) begin
            chk({nm, " dz_idle"}, bus.busy, 0);
            chk({nm, " dz_no_start"}, 64'(start_cnt - s0), 0);
        end else begin
            chk({nm, " rel_start_low"}, bus.div_start, 0);
            chk({nm, " rel_busy"}, bus.busy, 1);
            repeat (REL_CYC) @(negedge clk);
            chk({nm, " rel_idle"}, bus.busy, 0);
        end
        m_last = eid;
    endtask

    typedef struct {
        bit           v0, v1;
        logic [W-1:0] a0, b0, a1, b1;
        int           dly;
        bit           eid;
        logic [W-1:0] eq, er;
        logic [1:0]   eerr;
        int           elat;
    } vec_t;

    vec_t tbl[9];

    initial begin
        #500000;
        $display("FAIL global_timeout cyc=%0d limit=50000", cyc);
        $fatal(1, "bench timed out");
    end

    initial begin
        int t, rc, sel, dly;
        bit v0, v1, id;
        logic [W-1:0] a0, b0, a1, b1, q, r;
        logic [1:0] err;
        int lat;

        //          v0 v1  a0   b0  a1   b1  dly       id  q     r    err     lat
        tbl[0] = '{1, 0, 100,   7,  0,   0,  34,       0,  14,   2,   ERR_OK, 36};
        tbl[1] = '{0, 1,   0,   0, 55,   0,   5,       1, 255,  55,   ERR_DZ,  1};
        tbl[2] = '{1, 0, 200,   3,  0,   0,   0,       0,  66,   2,   ERR_OK,  2};
        tbl[3] = '{0, 1,   0,   0,  9,  10,   5,       1,   0,   9,   ERR_OK,  7};
        tbl[4] = '{1, 0,  50,   5,  0,   0,  -1,       0,   0,   0,   ERR_TO, 65};
        tbl[5] = '{0, 1,   0,   0, 77,   4,  63,       1,  19,   1,   ERR_OK, 65};
        tbl[6] = '{1, 0,  77,   4,  0,   0,  64,       0,   0,   0,   ERR_TO, 65};
        tbl[7] = '{1, 0,   0,   0,  0,   0,   3,       0, 255,   0,   ERR_DZ,  1};
        tbl[8] = '{0, 1,   0,   0, 255,  1,   1,       1, 255,   0,   ERR_OK,  3};

        rst_n = 1'b0;
        drop_valids();
        bus.req0_a = '0; bus.req0_b = '0; bus.req1_a = '0; bus.req1_b = '0;
        repeat (3) @(negedge clk);
        chk("rst busy", bus.busy, 0);
        chk("rst div_start", bus.div_start, 0);
        chk("rst rsp_valid", bus.rsp_valid, 0);
        chk("rst rsp_q", bus.rsp_q, 0);
        chk("rst rsp_r", bus.rsp_r, 0);
        chk("rst rsp_err", bus.rsp_err, 0);
        chk("rst rsp_id", bus.rsp_id, 0);
        chk("rst div_a", bus.div_a, 0);
        chk("rst div_b", bus.div_b, 0);
        chk("rst ready", {bus.req0_ready, bus.req1_ready}, 0);
        rst_n = 1'b1;
        @(negedge clk);

        // tie fairness with both requesters held valid
        for (int i = 0; i < 4; i++)
            run_job($sformatf("tie%0d", i), 1, 1, 100, 7, 90, 8, 3, 1, bit'(i % 2),
                    (i % 2) ? 8'd11 : 8'd14, 8'd2, ERR_OK, 5);
        drop_valids();

        for (int i = 0; i < 9; i++)
            run_job($sformatf("vec%0d", i), tbl[i].v0, tbl[i].v1, tbl[i].a0, tbl[i].b0,
                    tbl[i].a1, tbl[i].b1, tbl[i].dly, 0, tbl[i].eid, tbl[i].eq, tbl[i].er,
                    tbl[i].eerr, tbl[i].elat);

        // done outside RUN must be ignored
        rc = rsp_cnt;
        spur = 1'b1;
        repeat (3) @(negedge clk);
        chk("spur busy", bus.busy, 0);
        spur = 1'b0;
        @(negedge clk);
        chk("spur no_rsp", 64'(rsp_cnt - rc), 0);

        // reset in the middle of RUN
        dly_cfg = -1;
        bus.req0_a = 10; bus.req0_b = 3;
        bus.req0_valid = 1'b1;
        #1;
        chk("rst_run hs", bus.req0_ready, 1);
        t = cyc;
        @(negedge clk);
        drop_valids();
        while (cyc < t + 10) @(negedge clk);
        chk("rst_run in_run", bus.div_start, 1);
        rc = rsp_cnt;
        rst_n = 1'b0;
        bus.req0_a = 20; bus.req0_b = 4; bus.req1_a = 30; bus.req1_b = 5;
        bus.req0_valid = 1'b1; bus.req1_valid = 1'b1;
        @(negedge clk);
        chk("rst_run busy", bus.busy, 0);
        chk("rst_run div_start", bus.div_start, 0);
        chk("rst_run rsp_valid", bus.rsp_valid, 0);
        chk("rst_run rsp_q", bus.rsp_q, 0);
        chk("rst_run rsp_r", bus.rsp_r, 0);
        chk("rst_run rsp_err", bus.rsp_err, 0);
        chk("rst_run div_a", bus.div_a, 0);
        chk("rst_run div_b", bus.div_b, 0);
        chk("rst_run ready", {bus.req0_ready, bus.req1_ready}, 0);
        drop_valids();
        rst_n = 1'b1;
        m_last = 1'b1;
        repeat (3) @(negedge clk);
        chk("rst_run no_rsp", 64'(rsp_cnt - rc), 0);
        run_job("rst_tie", 1, 1, 20, 4, 30, 5, 2, 0, 0, 5, 0, ERR_OK, 4);

        // randomized jobs against the reference model
        for (int i = 0; i < 30; i++) begin
            sel = $urandom_range(1, 3);
            v0  = sel[0];
            v1  = sel[1];
            a0  = W'($urandom);
            a1  = W'($urandom);
            b0  = ($urandom_range(0, 5) == 0) ? '0 : W'($urandom);
            b1  = ($urandom_range(0, 5) == 0) ? '0 : W'($urandom);
            sel = $urandom_range(0, 9);
            dly = (sel == 0) ? -1 : (sel == 1) ? int'($urandom_range(60, 70)) : int'($urandom_range(0, 8));
            ref_model(v0, v1, a0, b0, a1, b1, dly, id, q, r, err, lat);
            run_job($sformatf("rnd%0d", i), v0, v1, a0, b0, a1, b1, dly, 0, id, q, r, err, lat);
        end

        chk("ready_only_idle", 64'(ready_bad), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
